// File: rtl/xbar_eval_ctrl.sv
// Evaluation controller for a nanowire crossbar: holds per-cell literal codes,
// drives the crossbar for one input assignment, waits to settle, samples the result.
module xbar_eval_ctrl #(
    parameter int ROWS   = 2,
    parameter int COLS   = 4,
    parameter int NVARS  = 4,
    parameter int SETTLE = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] cfg_row,
    input  logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] cfg_col,
    input  logic [3:0]                                cfg_lit,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [NVARS-1:0]                          req_vec,
    output logic [ROWS*COLS-1:0]                      cell_en,
    output logic                                      xbar_drive,
    input  logic                                      xbar_out,
    output logic                                      rsp_valid,
    input  logic                                      rsp_ready,
    output logic                                      rsp_result,
    output logic [15:0]                               eval_count
);

    localparam int NCELL = ROWS * COLS;
    localparam int VW    = (NVARS < 4) ? 4 : NVARS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_RESP
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        settle_cnt_reg, settle_cnt_next;
    logic [NCELL-1:0]  cell_en_reg;
    logic [NCELL-1:0]  cell_en_calc;
    logic              xbar_drive_reg;
    logic              rsp_result_reg;
    logic [15:0]       eval_count_reg;
    logic              cfg_fire;
    logic              req_fire;
    logic              rsp_fire;
    logic [31:0]       cfg_idx;
    logic [VW-1:0]     vec_pad;

    assign cfg_ready = (state_reg == ST_IDLE);
    assign req_ready = (state_reg == ST_IDLE) && !cfg_valid;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign req_fire  = req_valid && req_ready;
    assign rsp_fire  = (state_reg == ST_RESP) && rsp_ready;
    assign cfg_idx   = 32'(cfg_row) * 32'(COLS) + 32'(cfg_col);
    // Zero-extend so a 2-bit variable index never reaches past the vector.
    assign vec_pad   = VW'(req_vec);

    generate
        for (genvar gi = 0; gi < NCELL; gi++) begin : g_cell
            logic [3:0] lit_reg;
            logic       en_bit;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lit_reg <= 4'b0000;
                end else if (cfg_fire && (cfg_idx == 32'(gi))) begin
                    lit_reg <= cfg_lit;
                end
            end

            always_comb begin
                en_bit = 1'b0;
                case (lit_reg[3:2])
                    2'b00:   en_bit = 1'b0;
                    2'b01:   en_bit = 1'b1;
                    2'b10:   en_bit = vec_pad[lit_reg[1:0]];
                    default: en_bit = ~vec_pad[lit_reg[1:0]];
                endcase
            end

            assign cell_en_calc[gi] = en_bit;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            settle_cnt_reg <= 4'd0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_fire) state_next = ST_APPLY;
            end
            ST_APPLY: begin
                if (SETTLE == 0) begin
                    state_next = ST_SAMPLE;
                end else begin
                    state_next      = ST_SETTLE;
                    settle_cnt_next = 4'(SETTLE);
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_reg <= 4'd1) begin
                    state_next      = ST_SAMPLE;
                    settle_cnt_next = 4'd0;
                end else begin
                    settle_cnt_next = settle_cnt_reg - 4'd1;
                end
            end
            ST_SAMPLE: state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Enables are captured on the accept edge so they are already valid in APPLY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cell_en_reg    <= '0;
            xbar_drive_reg <= 1'b0;
            rsp_result_reg <= 1'b0;
            eval_count_reg <= 16'd0;
        end else begin
            if (req_fire) begin
                cell_en_reg    <= cell_en_calc;
                xbar_drive_reg <= 1'b1;
            end
            if (state_reg == ST_SAMPLE) begin
                rsp_result_reg <= xbar_out;
                cell_en_reg    <= '0;
                xbar_drive_reg <= 1'b0;
            end
            if (rsp_fire && (eval_count_reg != 16'hFFFF)) begin
                eval_count_reg <= eval_count_reg + 16'd1;
            end
        end
    end

    assign cell_en    = cell_en_reg;
    assign xbar_drive = xbar_drive_reg;
    assign rsp_valid  = (state_reg == ST_RESP);
    assign rsp_result = rsp_result_reg;
    assign eval_count = eval_count_reg;

endmodule

// File: tb/tb_xbar_eval_ctrl.sv
// Directed bench for xbar_eval_ctrl using a stub crossbar whose output is
// the AND of cell (0,0) and cell (1,0).
module tb_xbar_eval_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [0:0]  cfg_row;
    logic [1:0]  cfg_col;
    logic [3:0]  cfg_lit;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_vec;
    logic [7:0]  cell_en;
    logic        xbar_drive;
    logic        xbar_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_result;
    logic [15:0] eval_count;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    assign xbar_out = cell_en[0] & cell_en[4];

    xbar_eval_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_row    (cfg_row),
        .cfg_col    (cfg_col),
        .cfg_lit    (cfg_lit),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_vec    (req_vec),
        .cell_en    (cell_en),
        .xbar_drive (xbar_drive),
        .xbar_out   (xbar_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .eval_count (eval_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic r, input logic [1:0] c, input logic [3:0] lit);
        cfg_row   = r;
        cfg_col   = c;
        cfg_lit   = lit;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        $display("cfg  row=%0d col=%0d lit=%b", r, c, lit);
    endtask

    // Issues a request and waits (bounded) for rsp_valid; latency counts from the accept cycle.
    task automatic do_eval(input logic [3:0] vec, output int lat, output logic res,
                           output logic [7:0] en_first, output logic en_stable,
                           output int drv_cycles);
        req_vec   = vec;
        req_valid = 1'b1;
        tick();
        req_valid  = 1'b0;
        lat        = 1;
        en_first   = cell_en;
        en_stable  = 1'b1;
        drv_cycles = 0;
        while (!rsp_valid && lat < 30) begin
            if (xbar_drive) begin
                drv_cycles++;
                if (cell_en !== en_first) en_stable = 1'b0;
            end
            tick();
            lat++;
        end
        res = rsp_result;
        $display("eval vec=%b lat=%0d cell_en=%h result=%b", vec, lat, en_first, res);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        cfg_row = '0; cfg_col = '0; cfg_lit = '0; req_vec = '0;
        tick(); tick();
        checks++; if ({cell_en, xbar_drive, rsp_valid, rsp_result} !== 11'd0)
            $display("FAIL reset_outputs: got %h required 0", {cell_en, xbar_drive, rsp_valid, rsp_result}); else passes++;
        checks++; if (eval_count !== 16'd0)
            $display("FAIL reset_count: got %0d required 0", eval_count); else passes++;
        rst_n = 1'b1;
        tick();
        checks++; if (cfg_ready !== 1'b1 || req_ready !== 1'b1)
            $display("FAIL reset_idle_ready: got cfg=%b req=%b required 1 1", cfg_ready, req_ready); else passes++;
    endtask

    task automatic test_var_and();
        int lat; logic res; logic [7:0] en; logic st; int drv;
        cfg_write(1'b0, 2'd0, 4'b1000);
        cfg_write(1'b1, 2'd0, 4'b1001);
        do_eval(4'b0011, lat, res, en, st, drv);
        checks++; if (lat !== 5) $display("FAIL and_latency: got %0d required 5", lat); else passes++;
        checks++; if (res !== 1'b1) $display("FAIL and_result: got %b required 1", res); else passes++;
        checks++; if (en !== 8'h11 || st !== 1'b1 || drv !== 4)
            $display("FAIL and_cell_en: got %h stable=%b drive=%0d required 11 1 4", en, st, drv); else passes++;
        finish_rsp();
        checks++; if (rsp_valid !== 1'b0 || eval_count !== 16'd1)
            $display("FAIL and_count: got valid=%b count=%0d required 0 1", rsp_valid, eval_count); else passes++;
    endtask

    task automatic test_var_zero();
        int lat; logic res; logic [7:0] en; logic st; int drv;
        do_eval(4'b0001, lat, res, en, st, drv);
        checks++; if (res !== 1'b0 || en !== 8'h01)
            $display("FAIL zero_result: got res=%b en=%h required 0 01", res, en); else passes++;
        finish_rsp();
        checks++; if (eval_count !== 16'd2) $display("FAIL zero_count: got %0d required 2", eval_count); else passes++;
    endtask

    task automatic test_negated();
        int lat; logic res; logic [7:0] en; logic st; int drv;
        cfg_write(1'b1, 2'd0, 4'b1101);
        do_eval(4'b0001, lat, res, en, st, drv);
        checks++; if (res !== 1'b1) $display("FAIL neg_result: got %b required 1", res); else passes++;
        checks++; if (en !== 8'h11 || st !== 1'b1 || drv !== 4)
            $display("FAIL neg_cell_en: got %h stable=%b drive=%0d required 11 1 4", en, st, drv); else passes++;
        finish_rsp();
    endtask

    task automatic test_cfg_priority();
        int lat;
        cfg_row = 1'b0; cfg_col = 2'd1; cfg_lit = 4'b0100;
        cfg_valid = 1'b1; req_valid = 1'b1; req_vec = 4'b0011;
        #1;
        checks++; if (req_ready !== 1'b0 || cfg_ready !== 1'b1)
            $display("FAIL prio_ready: got req=%b cfg=%b required 0 1", req_ready, cfg_ready); else passes++;
        tick();
        cfg_valid = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || xbar_drive !== 1'b0)
            $display("FAIL prio_wait: got req_ready=%b drive=%b required 1 0", req_ready, xbar_drive); else passes++;
        tick();
        req_valid = 1'b0;
        checks++; if (xbar_drive !== 1'b1 || cell_en !== 8'h03)
            $display("FAIL prio_apply: got drive=%b en=%h required 1 03", xbar_drive, cell_en); else passes++;
        lat = 1;
        while (!rsp_valid && lat < 30) begin tick(); lat++; end
        checks++; if (lat !== 5 || rsp_result !== 1'b0)
            $display("FAIL prio_rsp: got lat=%0d res=%b required 5 0", lat, rsp_result); else passes++;
        $display("eval vec=0011 lat=%0d result=%b (after cfg)", lat, rsp_result);
        finish_rsp();
    endtask

    task automatic test_hold();
        int lat; logic res; logic [7:0] en; logic st; int drv; logic ok;
        do_eval(4'b0001, lat, res, en, st, drv);
        checks++; if (res !== 1'b1 || en !== 8'h13)
            $display("FAIL hold_first: got res=%b en=%h required 1 13", res, en); else passes++;
        cfg_row = 1'b1; cfg_col = 2'd0; cfg_lit = 4'b0000; cfg_valid = 1'b1;
        req_vec = 4'b0011; req_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid !== 1'b1 || rsp_result !== 1'b1 || cfg_ready !== 1'b0 || req_ready !== 1'b0 || xbar_drive !== 1'b0)
                ok = 1'b0;
            tick();
        end
        checks++; if (ok !== 1'b1)
            $display("FAIL hold_stable: got valid=%b res=%b cfg_ready=%b req_ready=%b required 1 1 0 0",
                     rsp_valid, rsp_result, cfg_ready, req_ready); else passes++;
        cfg_valid = 1'b0; req_valid = 1'b0;
        finish_rsp();
        checks++; if (eval_count !== 16'd5) $display("FAIL hold_count: got %0d required 5", eval_count); else passes++;
    endtask

    task automatic test_back_to_back();
        int lat; logic res; logic [7:0] en; logic st; int drv;
        do_eval(4'b0001, lat, res, en, st, drv);
        checks++; if (res !== 1'b1 || en !== 8'h13)
            $display("FAIL b2b_ignored_cfg: got res=%b en=%h required 1 13", res, en); else passes++;
        rsp_ready = 1'b1; req_valid = 1'b1; req_vec = 4'b0011;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL b2b_idle: got valid=%b req_ready=%b required 0 1", rsp_valid, req_ready); else passes++;
        tick();
        req_valid = 1'b0;
        checks++; if (xbar_drive !== 1'b1 || cell_en !== 8'h03)
            $display("FAIL b2b_apply: got drive=%b en=%h required 1 03", xbar_drive, cell_en); else passes++;
        lat = 1;
        while (!rsp_valid && lat < 30) begin tick(); lat++; end
        checks++; if (lat !== 5 || rsp_result !== 1'b0)
            $display("FAIL b2b_rsp: got lat=%0d res=%b required 5 0", lat, rsp_result); else passes++;
        $display("eval vec=0011 lat=%0d result=%b (back-to-back)", lat, rsp_result);
        finish_rsp();
        checks++; if (eval_count !== 16'd7) $display("FAIL b2b_count: got %0d required 7", eval_count); else passes++;
    endtask

    task automatic test_reset_mid();
        int lat; logic res; logic [7:0] en; logic st; int drv; logic saw_valid;
        req_vec = 4'b0011; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (xbar_drive !== 1'b1) $display("FAIL mid_pre_drive: got %b required 1", xbar_drive); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({cell_en, xbar_drive, rsp_valid, rsp_result} !== 11'd0 || eval_count !== 16'd0)
            $display("FAIL mid_async_clear: got %h count=%0d required 0 0",
                     {cell_en, xbar_drive, rsp_valid, rsp_result}, eval_count); else passes++;
        saw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid) saw_valid = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid) saw_valid = 1'b1;
        end
        checks++; if (saw_valid !== 1'b0) $display("FAIL mid_no_rsp: got %b required 0", saw_valid); else passes++;
        do_eval(4'b1111, lat, res, en, st, drv);
        checks++; if (res !== 1'b0 || en !== 8'h00 || lat !== 5)
            $display("FAIL mid_cfg_lost: got res=%b en=%h lat=%0d required 0 00 5", res, en, lat); else passes++;
        finish_rsp();
        checks++; if (eval_count !== 16'd1) $display("FAIL mid_count: got %0d required 1", eval_count); else passes++;
    endtask

    initial begin
        test_reset();
        test_var_and();
        test_var_zero();
        test_negated();
        test_cfg_priority();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/xbar_eval_ctrl.md
XBAR_EVAL_CTRL -- requirements
Module: xbar_eval_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- ROWS, 2, crossbar rows (nanowire levels).
- COLS, 4, crossbar columns.
- NVARS, 4, number of Boolean input variables.
- SETTLE, 2, cycles between drive-on and sample (0..15 legal).
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- cfg_valid, in, 1, cell-config write request.
- cfg_ready, out, 1, cell-config write accepted.
- cfg_row, in, clog2(ROWS), cell row.
- cfg_col, in, clog2(COLS), cell column.
- cfg_lit, in, 4, literal code: [3:2] mode (00 off, 01 const on, 10 var, 11 negated var), [1:0] var index.
- req_valid, in, 1, evaluation request.
- req_ready, out, 1, evaluation request accepted.
- req_vec, in, NVARS, input assignment; bit i is variable i.
- cell_en, out, ROWS*COLS, per-cell conduct enable to the crossbar; index row*COLS+col.
- xbar_drive, out, 1, input-nanowire drive enable.
- xbar_out, in, 1, crossbar output sense line.
- rsp_valid, out, 1, result available.
- rsp_ready, in, 1, result consumed.
- rsp_result, out, 1, sampled function value.
- eval_count, out, 16, completed evaluations, saturating.

Function
REQ-003 The block SHALL hold a ROWS*COLS array of 4-bit literal codes, written only through the cfg handshake.
REQ-004 The FSM SHALL have states IDLE, APPLY, SETTLE, SAMPLE and RESP.
REQ-005 cfg_ready SHALL be high only in IDLE; a write occurs on a cycle where cfg_valid and cfg_ready are both high; the new code is visible to the next evaluation.
REQ-006 req_ready SHALL equal (state==IDLE) AND NOT cfg_valid, so a simultaneous config write takes priority and the request waits.
REQ-007 On request accept in cycle T, the block SHALL latch req_vec and enter APPLY at T+1.
REQ-008 In APPLY the block SHALL register cell_en from the latched vector: off gives 0; const gives 1; var gives vec[idx]; negated var gives ~vec[idx]. It SHALL also assert xbar_drive.
REQ-009 The FSM SHALL go from APPLY to SETTLE and stay there exactly SETTLE cycles, counted by a 4-bit down-counter. If SETTLE==0 it SHALL go from APPLY directly to SAMPLE.
REQ-010 In SAMPLE the block SHALL capture xbar_out into rsp_result, then go to RESP. For SETTLE=2, with accept at T, capture occurs at T+4 and rsp_valid rises at T+5.
REQ-011 cell_en and xbar_drive SHALL be high/valid from APPLY through SAMPLE inclusive, and SHALL be 0 in IDLE and RESP.
REQ-012 In RESP, rsp_valid SHALL be high and rsp_result stable until rsp_ready is high; the block then returns to IDLE on the next cycle and increments eval_count.
REQ-013 eval_count SHALL saturate at 16'hFFFF with no wrap-around.
REQ-014 cfg_valid and req_valid outside IDLE SHALL be ignored, with no state change, until IDLE is reached.
REQ-015 Back-to-back operation SHALL be supported: if a request is pending in the IDLE cycle following RESP, it is accepted in that cycle.

Reset
REQ-016 While rst_n is low, asynchronously: state=IDLE; cell_en=0; xbar_drive=0; rsp_valid=0; rsp_result=0; eval_count=0; settle counter=0; all literal codes=4'b0000 (off).
REQ-017 Reset asserted mid-evaluation SHALL abort the evaluation with no response, drop xbar_drive immediately, and lose the configuration.
REQ-018 After rst_n deasserts, the first accepted request SHALL NOT be earlier than the first rising clk edge with rst_n high.

Verification
REQ-019 The bench SHALL cover the following directed scenarios, using a stub xbar_out = cell_en[0] & cell_en[4].
- After reset, write cell(0,0)=4'b1000 (var a) and cell(1,0)=4'b1001 (var b); evaluate vec=4'b0011. Required: rsp_result=1, rsp_valid at accept+5, eval_count=1.
- Same configuration, evaluate vec=4'b0001. Required: rsp_result=0.
- Set cell(1,0)=4'b1101 (~b) and evaluate vec=4'b0001. Required: rsp_result=1, cell_en=8'h11 during APPLY..SAMPLE.
- Drive cfg_valid and req_valid in the same IDLE cycle. Required: the config write is taken, req_ready=0 that cycle, and the request is accepted on the following cycle.
- Hold rsp_ready=0 for 10 cycles in RESP. Required: rsp_valid and rsp_result stay stable, cfg_ready=0, req_ready=0.
- Assert rst_n=0 during SETTLE. Required: all outputs go to 0 immediately, with no rsp_valid; a later evaluation with all cells off returns rsp_result=0.
